// File: rtl/ram_pkg.sv
// ram_pkg: shared FSM encoding, default geometry and address-split helpers for banked_ram_ctrl.
// Rev 1.0
`default_nettype none

package ram_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int unsigned nbe_of(input int unsigned data_w, input int unsigned byte_w);
    return data_w / byte_w;
  endfunction

  function automatic int unsigned bank_depth_of(input int unsigned addr_w, input int unsigned bank_bits);
    return 32'd1 << (addr_w - bank_bits);
  endfunction

  // Upper BANK_BITS of the word address pick the bank, the rest is the row inside it.
  function automatic int unsigned bank_of(input logic [31:0] addr, input int unsigned addr_w,
                                          input int unsigned bank_bits);
    return (addr >> (addr_w - bank_bits)) & ((32'd1 << bank_bits) - 32'd1);
  endfunction

  function automatic int unsigned row_of(input logic [31:0] addr, input int unsigned addr_w,
                                         input int unsigned bank_bits);
    return addr & ((32'd1 << (addr_w - bank_bits)) - 32'd1);
  endfunction

  localparam int unsigned DEF_DATA_W     = 16;
  localparam int unsigned DEF_BYTE_W     = 8;
  localparam int unsigned DEF_ADDR_W     = 12;
  localparam int unsigned DEF_BANK_BITS  = 2;
  localparam int unsigned DEF_NBE        = nbe_of(DEF_DATA_W, DEF_BYTE_W);
  localparam int unsigned DEF_BANK_DEPTH = bank_depth_of(DEF_ADDR_W, DEF_BANK_BITS);

endpackage

`default_nettype wire

// File: rtl/ram_bank.sv
// ram_bank: one RAM bank with byte-lane sync writes and a registered read port.
// Rev 1.0
`default_nettype none

module ram_bank #(
  parameter int DATA_W = 16,
  parameter int BYTE_W = 8,
  parameter int ROW_W  = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [ROW_W-1:0]         row_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [DATA_W/BYTE_W-1:0] be_i,
  output logic [DATA_W-1:0]        rdata_o
);

  localparam int NBE = DATA_W / BYTE_W;

  logic [DATA_W-1:0] mem_q [1 << ROW_W];
  logic [DATA_W-1:0] rdata_q;

  // Array is left unreset; the controller's zero-fill sweep initialises it.
  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      for (int i = 0; i < NBE; i++) begin
        if (be_i[i]) mem_q[row_i][i*BYTE_W +: BYTE_W] <= wdata_i[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[row_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/banked_ram_ctrl.sv
// banked_ram_ctrl: banked single-port RAM with zero-fill after reset, req/ready handshake, byte lanes.
// Rev 1.0 -- define READ_PIPE_EN to add a second read output stage (latency 2).
`default_nettype none

module banked_ram_ctrl
  import ram_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int BYTE_W    = 8,
  parameter int ADDR_W    = 12,
  parameter int BANK_BITS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_i,
  input  logic                     we_i,
  input  logic [ADDR_W-1:0]        addr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [DATA_W/BYTE_W-1:0] be_i,
  output logic                     ready_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     rvalid_o,
  output logic                     init_done_o
);

  localparam int NBE        = int'(nbe_of(DATA_W, BYTE_W));
  localparam int ROW_W      = ADDR_W - BANK_BITS;
  localparam int NBANK      = 1 << BANK_BITS;
  localparam int BANK_DEPTH = int'(bank_depth_of(ADDR_W, BANK_BITS));

  state_e                 state_q, state_d;
  logic [ROW_W-1:0]       cnt_q, cnt_d;
  logic [BANK_BITS-1:0]   tag_q, tag_d;
  logic                   rvalid_q;
  logic                   rd_acc;
  logic                   ready;
  logic [BANK_BITS-1:0]   req_bank;
  logic [ROW_W-1:0]       req_row;
  logic [NBANK-1:0]       bank_en;
  logic                   bank_we;
  logic [ROW_W-1:0]       bank_row;
  logic [DATA_W-1:0]      bank_wdata;
  logic [NBE-1:0]         bank_be;
  logic [DATA_W-1:0]      bank_rdata [NBANK];

  assign req_bank = BANK_BITS'(bank_of(32'(addr_i), ADDR_W, BANK_BITS));
  assign req_row  = ROW_W'(row_of(32'(addr_i), ADDR_W, BANK_BITS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      tag_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tag_q    <= tag_d;
      rvalid_q <= rd_acc;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tag_d      = tag_q;
    rd_acc     = 1'b0;
    ready      = 1'b0;
    bank_en    = '0;
    bank_we    = 1'b0;
    bank_row   = req_row;
    bank_wdata = wdata_i;
    bank_be    = be_i;
    case (state_q)
      ST_INIT: begin
        // Zero row cnt of every bank at once.
        bank_en    = '1;
        bank_we    = 1'b1;
        bank_row   = cnt_q;
        bank_wdata = '0;
        bank_be    = '1;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == ROW_W'(BANK_DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        ready = 1'b1;
        if (req_i) begin
          bank_en[req_bank] = 1'b1;
          bank_we           = we_i;
          if (!we_i) begin
            rd_acc = 1'b1;
            tag_d  = req_bank;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    ram_bank #(
      .DATA_W (DATA_W),
      .BYTE_W (BYTE_W),
      .ROW_W  (ROW_W)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .en_i    (bank_en[b]),
      .we_i    (bank_we),
      .row_i   (bank_row),
      .wdata_i (bank_wdata),
      .be_i    (bank_be),
      .rdata_o (bank_rdata[b])
    );
  end

  assign ready_o     = ready;
  assign init_done_o = (state_q == ST_RUN);

`ifdef READ_PIPE_EN
  logic              rvalid2_q;
  logic [DATA_W-1:0] rdata2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid2_q <= 1'b0;
      rdata2_q  <= '0;
    end else begin
      rvalid2_q <= rvalid_q;
      if (rvalid_q) rdata2_q <= bank_rdata[tag_q];
    end
  end

  assign rdata_o  = rdata2_q;
  assign rvalid_o = rvalid2_q && !rst;
`else
  // Bank read registers only move on a read and tag_q only on a read, so the mux holds between pulses.
  assign rdata_o  = bank_rdata[tag_q];
  // A read caught by a reset in its response cycle must not surface.
  assign rvalid_o = rvalid_q && !rst;
`endif

endmodule

`default_nettype wire

// File: tb/tb_banked_ram_ctrl.sv
// tb_banked_ram_ctrl: table-driven vectors plus reset/init sequences, scoreboard-checked reads.
// Rev 1.0
`default_nettype none

module tb_banked_ram_ctrl;

`ifdef READ_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [11:0] addr;
  logic [15:0] wdata;
  logic [1:0]  be;
  logic        ready;
  logic [15:0] rdata;
  logic        rvalid;
  logic        init_done;

  banked_ram_ctrl #(
    .DATA_W    (16),
    .BYTE_W    (8),
    .ADDR_W    (12),
    .BANK_BITS (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .we_i        (we),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .be_i        (be),
    .ready_o     (ready),
    .rdata_o     (rdata),
    .rvalid_o    (rvalid),
    .init_done_o (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          due;
  } sb_t;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp;
  } vec_t;

  sb_t         sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  logic [15:0] last_data = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sample outputs on the falling edge, then advance past the next rising edge.
  task automatic step();
    sb_t e;
    @(negedge clk);
    if (rvalid) begin
      if (sb.size() == 0) begin
        check("unexpected_rvalid", 32'(rvalid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("read_cycle", 32'(cyc), 32'(e.due));
        check("read_data", 32'(rdata), 32'(e.data));
        last_data = e.data;
      end
    end else if (sb.size() > 0 && cyc > sb[0].due) begin
      e = sb.pop_front();
      check("missing_rvalid", 32'(rvalid), 32'd1);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [15:0] d, input logic [1:0] b);
    req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
    step();
    req = 1'b0; we = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] a, input logic [15:0] exp);
    sb_t e;
    req = 1'b1; we = 1'b0; addr = a;
    step();
    e.data = exp;
    e.due  = cyc + LAT - 1;
    sb.push_back(e);
    req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 10) begin
      step();
      n++;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic wait_init();
    int n = 0;
    while (!ready && n < 1100) begin
      step();
      n++;
    end
    check("init_cycles", 32'(n), 32'd1024);
    check("init_done", 32'(init_done), 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{1'b1, 12'h000, 16'hA5C3, 2'b11, 16'h0000},
      '{1'b1, 12'hC00, 16'hBEEF, 2'b11, 16'h0000},
      '{1'b0, 12'h000, 16'h0000, 2'b00, 16'hA5C3},
      '{1'b0, 12'hC00, 16'h0000, 2'b00, 16'hBEEF},
      '{1'b0, 12'h400, 16'h0000, 2'b00, 16'h0000},
      '{1'b0, 12'h7FF, 16'h0000, 2'b00, 16'h0000},
      '{1'b1, 12'h000, 16'h1234, 2'b01, 16'h0000},
      '{1'b0, 12'h000, 16'h0000, 2'b00, 16'hA534},
      '{1'b1, 12'h000, 16'hFFFF, 2'b00, 16'h0000},
      '{1'b0, 12'h000, 16'h0000, 2'b00, 16'hA534},
      '{1'b1, 12'h001, 16'h1111, 2'b11, 16'h0000},
      '{1'b1, 12'h401, 16'h2222, 2'b11, 16'h0000},
      '{1'b1, 12'h801, 16'h3333, 2'b11, 16'h0000},
      '{1'b1, 12'hC01, 16'h4444, 2'b10, 16'h0000},
      '{1'b0, 12'h001, 16'h0000, 2'b00, 16'h1111},
      '{1'b0, 12'h401, 16'h0000, 2'b00, 16'h2222},
      '{1'b0, 12'h801, 16'h0000, 2'b00, 16'h3333},
      '{1'b0, 12'hC01, 16'h0000, 2'b00, 16'h4400},
      '{1'b1, 12'h123, 16'h5555, 2'b11, 16'h0000},
      '{1'b0, 12'h123, 16'h0000, 2'b00, 16'h5555}
    };

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    step();
    step();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    rst = 1'b0;
    wait_init();

    do_read(12'h000, 16'h0000);
    do_read(12'h7FF, 16'h0000);
    do_read(12'hFFF, 16'h0000);
    drain();

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].we) do_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
      else            do_read(vecs[i].addr, vecs[i].exp);
    end
    drain();

    for (int i = 0; i < 3; i++) step();
    check("rdata_hold", 32'(rdata), 32'(last_data));
    check("rvalid_idle", 32'(rvalid), 32'd0);

    // Read accepted, then reset lands in its response cycle.
    req = 1'b1; we = 1'b0; addr = 12'h123;
    step();
    req = 1'b0;
    rst = 1'b1;
    step();
    check("midrst_rvalid", 32'(rvalid), 32'd0);
    step();
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_init_done", 32'(init_done), 32'd0);
    rst = 1'b0;
    wait_init();
    do_read(12'h123, 16'h0000);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
